// File: rtl/carry_lookahead_adder_4bit_unit.sv
// 4-bit carry-lookahead adder slice: registered sum, carry-out, group propagate/generate.
// Defining CLA_INPUT_REG_EN adds an input register stage, so the latency becomes 2 clocks.
module carry_lookahead_adder_4bit_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out,
  output logic       PG,
  output logic       GG,
  output logic       out_valid
);

  localparam int unsigned W = 4;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_ci;
  logic         op_valid;

`ifdef CLA_INPUT_REG_EN
  // Operand capture stage; data loads only on valid so unknowns never enter it.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_ci    <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= in_valid;
      if (in_valid) begin
        op_a  <= in0;
        op_b  <= in1;
        op_ci <= carry_in;
      end
    end
  end
`else
  assign op_a     = in0;
  assign op_b     = in1;
  assign op_ci    = carry_in;
  assign op_valid = in_valid;
`endif

  logic [W-1:0] g_c;
  logic [W-1:0] p_c;
  logic [W:0]   c_c;
  logic [W-1:0] sum_c;
  logic         pg_c;
  logic         gg_c;

  assign g_c = op_a & op_b;
  assign p_c = op_a ^ op_b;

  // Flat two-level lookahead carries built only from g/p/carry_in.
  assign c_c[0] = op_ci;
  assign c_c[1] = g_c[0]
                | (p_c[0] & op_ci);
  assign c_c[2] = g_c[1]
                | (p_c[1] & g_c[0])
                | (p_c[1] & p_c[0] & op_ci);
  assign c_c[3] = g_c[2]
                | (p_c[2] & g_c[1])
                | (p_c[2] & p_c[1] & g_c[0])
                | (p_c[2] & p_c[1] & p_c[0] & op_ci);
  assign c_c[4] = g_c[3]
                | (p_c[3] & g_c[2])
                | (p_c[3] & p_c[2] & g_c[1])
                | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
                | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & op_ci);

  assign sum_c = p_c ^ c_c[W-1:0];

  // Group terms are carry_in independent so a second-level unit can chain slices.
  assign pg_c = &p_c;
  assign gg_c = g_c[3]
              | (p_c[3] & g_c[2])
              | (p_c[3] & p_c[2] & g_c[1])
              | (p_c[3] & p_c[2] & p_c[1] & g_c[0]);

  // Result registers hold while no valid operands arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      PG        <= 1'b0;
      GG        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= op_valid;
      if (op_valid) begin
        sum       <= sum_c;
        carry_out <= c_c[W];
        PG        <= pg_c;
        GG        <= gg_c;
      end
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder_4bit_unit.sv
// Self-checking bench for carry_lookahead_adder_4bit_unit against an arithmetic reference model.
// The latency follows CLA_INPUT_REG_EN in the same way as the design.
module tb_carry_lookahead_adder_4bit_unit;

`ifdef CLA_INPUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       carry_in;
  logic [3:0] sum;
  logic       carry_out;
  logic       PG;
  logic       GG;
  logic       out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Expected output registers.
  logic [3:0] m_sum = '0;
  logic       m_co  = 1'b0;
  logic       m_pg  = 1'b0;
  logic       m_gg  = 1'b0;
  logic       m_ov  = 1'b0;
  // Expected operand stage (used only when the input register is present).
  logic       s_v   = 1'b0;
  logic [3:0] s_a   = '0;
  logic [3:0] s_b   = '0;
  logic       s_ci  = 1'b0;

  carry_lookahead_adder_4bit_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out),
    .PG        (PG),
    .GG        (GG),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference from plain arithmetic: {carry, sum} is the integer sum, PG means
  // every bit position differs, GG means a+b overflows even with carry_in=0.
  function automatic logic [6:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int t;
    int u;
    logic [3:0] s;
    logic co, pg, gg;
    t  = int'(a) + int'(b) + int'(ci);
    u  = int'(a) + int'(b);
    s  = 4'(t % 16);
    co = (t > 15);
    pg = ((a ^ b) == 4'hF);
    gg = (u > 15);
    return {s, co, pg, gg};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock, then compare every output after the edge.
  task automatic tick();
    logic       ev;
    logic [3:0] ea, eb;
    logic       eci;
    logic [6:0] r;
    if (LAT == 2) begin
      ev = s_v; ea = s_a; eb = s_b; eci = s_ci;
      if (rst) begin
        s_v = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0;
      end else begin
        s_v = in_valid;
        if (in_valid) begin
          s_a = in0; s_b = in1; s_ci = carry_in;
        end
      end
    end else begin
      ev = in_valid; ea = in0; eb = in1; eci = carry_in;
    end
    if (rst) begin
      m_sum = '0; m_co = 1'b0; m_pg = 1'b0; m_gg = 1'b0; m_ov = 1'b0;
    end else begin
      m_ov = ev;
      if (ev) begin
        r = ref_add(ea, eb, eci);
        {m_sum, m_co, m_pg, m_gg} = r;
      end
    end
    @(posedge clk);
    #1;
    chk("sum",       8'(sum),       8'(m_sum));
    chk("carry_out", 8'(carry_out), 8'(m_co));
    chk("pg",        8'(PG),        8'(m_pg));
    chk("gg",        8'(GG),        8'(m_gg));
    chk("out_valid", 8'(out_valid), 8'(m_ov));
    chk("pg_gg_excl", 8'(PG & GG),  8'h00);
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
    in_valid = v; in0 = a; in1 = b; carry_in = ci;
  endtask

  // Single operation followed by idle cycles up to the result, checked against constants.
  task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci,
                          input logic [3:0] es, input logic eco, input logic epg, input logic egg);
    drive(1'b1, a, b, ci);
    tick();
    drive(1'b0, 4'hx, 4'hx, 1'bx);
    repeat (LAT - 1) tick();
    chk({tag, "_sum"}, 8'(sum),       8'(es));
    chk({tag, "_co"},  8'(carry_out), 8'(eco));
    chk({tag, "_pg"},  8'(PG),        8'(epg));
    chk({tag, "_gg"},  8'(GG),        8'(egg));
    chk({tag, "_ov"},  8'(out_valid), 8'h01);
    tick();
    chk({tag, "_ov_pulse"}, 8'(out_valid), 8'h00);
  endtask

  initial begin
    // Reset with live all-ones operands.
    rst = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    repeat (2) tick();
    chk("rst_sum", 8'(sum), 8'h00);
    chk("rst_ov",  8'(out_valid), 8'h00);
    rst = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    tick();

    directed("basic",   4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b0, 1'b0);
    directed("gen1",    4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1);
    directed("gen2",    4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0, 1'b1);
    directed("prop_c1", 4'd10, 4'd5,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0);
    directed("prop_c0", 4'd10, 4'd5,  1'b0, 4'd15, 1'b0, 1'b1, 1'b0);

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          drive(1'b1, 4'(a), 4'(b), 1'(c));
          tick();
        end

    // Hold: operands change (including unknowns) while in_valid is low.
    drive(1'b1, 4'd7, 4'd6, 1'b1);
    tick();
    drive(1'b0, 4'd2, 4'd9, 1'b0);
    repeat (LAT) tick();
    chk("hold_sum", 8'(sum), 8'd14);
    drive(1'b0, 4'hx, 4'hx, 1'bx);
    repeat (3) tick();
    chk("hold_x_sum", 8'(sum), 8'd14);
    chk("hold_x_ov",  8'(out_valid), 8'h00);

    // Mid-stream reset: the operand in the reset cycle must never surface.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      rst = (i == 3);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (3) tick();

    // Random traffic with random valid gaps, resets and unknown idle operands.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0)
        drive(1'b0, 4'hx, 4'hx, 1'bx);
      else
        drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      rst = ($urandom_range(49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
